serial_frame_rx: RTL
====================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 44: data bits per frame, legal range 2..64.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in frame_data[FRAME_W-1]; 0 = first received bit lands in frame_data[0].
REQ-003 The block SHALL have parameter PAR_EN, default 0: 1 = one parity bit follows the data bits.
REQ-004 The block SHALL have parameter PAR_ODD, default 0: 1 = odd parity; 0 = even parity.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port ain, input, 1 bit: serial data, sampled only when bit_en=1.
REQ-008 The block SHALL have port bit_en, input, 1 bit: bit strobe.
REQ-009 The block SHALL have port sof, input, 1 bit: start-of-frame, qualified by bit_en.
REQ-010 The block SHALL have port frame_data, output, FRAME_W bits: last completed frame.
REQ-011 The block SHALL have port frame_valid, output, 1 bit: frame_data holds an unconsumed frame.
REQ-012 The block SHALL have port frame_ready, input, 1 bit: consumer accepts the frame.
REQ-013 The block SHALL have port parity_err, output, 1 bit: parity error of the frame in frame_data; 0 when PAR_EN=0.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky; a completed frame was dropped.
REQ-015 The block SHALL have port abort, output, 1 bit: one-cycle pulse when an in-progress frame is discarded.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in SHIFT or PAR state.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and PAR, plus a bit counter of width clog2(FRAME_W+1).
REQ-018 IDLE: bit_en&sof SHALL sample ain as data bit 0, set count=1, and go to SHIFT; bit_en without sof SHALL be ignored.
REQ-019 SHIFT: each bit_en SHALL sample ain into the next bit position per MSB_FIRST and increment count; cycles with bit_en=0 SHALL hold all state.
REQ-020 When data bit FRAME_W is sampled, the FSM SHALL go to PAR if PAR_EN=1, otherwise complete the frame and return to IDLE.
REQ-021 PAR: the next bit_en SHALL sample the parity bit, complete the frame and return to IDLE.
REQ-022 parity_err SHALL equal (XOR of data bits ^ parity bit) ^ PAR_ODD, i.e. nonzero on mismatch.
REQ-023 Completion SHALL load frame_data and parity_err and set frame_valid on the same clock edge that samples the final bit (zero extra latency).
REQ-024 Handshake: frame_valid SHALL stay high, with frame_data and parity_err stable, until a cycle with frame_valid&frame_ready; frame_valid SHALL then clear on that edge.
REQ-025 Completion while frame_valid=1 and frame_ready=0: the new frame SHALL be dropped, the output SHALL keep the old frame, and overrun SHALL set to 1.
REQ-026 Completion in the same cycle as frame_valid&frame_ready: the new frame SHALL load, frame_valid SHALL stay 1, and overrun SHALL not set.
REQ-027 overrun SHALL clear only on reset.
REQ-028 bit_en&sof in SHIFT or PAR SHALL pulse abort for one cycle, discard the partial frame, and restart: ain becomes data bit 0 and count=1.
REQ-029 sof without bit_en SHALL have no effect.
REQ-030 The deserialiser SHALL not depend on the output register state; receiving a frame SHALL never stall.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, count 0, shift register 0, frame_data 0, frame_valid 0, parity_err 0, overrun 0, abort 0, busy 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; the first frame after release SHALL require a new sof.
REQ-033 Reset SHALL take effect with no clock edge; release SHALL be synchronised externally.

Verification
REQ-034 With FRAME_W=8, MSB_FIRST=1, PAR_EN=0: sof+bits 1,0,1,1,0,0,1,0 with frame_ready=1 -> frame_data=8'hB2, frame_valid high for 1 cycle at the 8th strobe edge.
REQ-035 Same bit stream with MSB_FIRST=0 -> frame_data=8'h4D.
REQ-036 With PAR_EN=1, PAR_ODD=0: data 8'hB2 then parity bit 0 -> parity_err=0; parity bit 1 -> parity_err=1.
REQ-037 With frame_ready=0, send two frames 8'hB2 then 8'h0F -> frame_data stays 8'hB2, overrun=1; then frame_ready=1 -> frame_valid clears.
REQ-038 sof re-asserted after 5 bits -> abort pulses once, new frame 8'hFF completes normally; rst pulsed low after 3 bits -> all outputs 0, busy=0, no frame until the next sof.
REQ-039 Default FRAME_W=44: 44 random bits with random bit_en gaps -> frame_data matches the reference model, and busy falls at the 44th strobe.

Source files
------------

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_rx
//  Purpose  : Strobed serial-to-parallel frame receiver. A frame starts with
//             sof qualified by bit_en and carries FRAME_W data bits
//             (MSB- or LSB-first), optionally followed by one parity bit.
//             Completed frames are presented on a valid/ready output
//             register. If the consumer is still holding the previous frame,
//             the new frame is dropped and the sticky overrun flag is set.
//             The deserialiser never stalls.
//  Ports    : clk         - clock, rising edge
//             rst         - asynchronous reset, active low
//             ain         - serial data, sampled when bit_en=1
//             bit_en      - bit strobe
//             sof         - start of frame, qualified by bit_en
//             frame_data  - last completed frame
//             frame_valid - frame_data holds an unconsumed frame
//             frame_ready - consumer accepts the frame
//             parity_err  - parity error of the frame in frame_data
//             overrun     - sticky, a completed frame was dropped
//             abort       - one-cycle pulse, partial frame discarded
//             busy        - receiving (SHIFT or PAR)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int FRAME_W   = 44,
    parameter int MSB_FIRST = 1,
    parameter int PAR_EN    = 0,
    parameter int PAR_ODD   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ain,
    input  logic               bit_en,
    input  logic               sof,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               parity_err,
    output logic               overrun,
    output logic               abort,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;

    logic [FRAME_W-1:0] w_shift_in;   // shift register with ain appended
    logic [FRAME_W-1:0] w_first;      // shift register holding only data bit 0
    logic               w_done;
    logic [FRAME_W-1:0] w_done_data;
    logic               w_done_perr;
    logic               w_abort;

    // Shift direction decides where the first bit ends up after FRAME_W bits.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_in = {r_shift[FRAME_W-2:0], ain};
            assign w_first    = {{(FRAME_W-1){1'b0}}, ain};
        end else begin : g_lsb_first
            assign w_shift_in = {ain, r_shift[FRAME_W-1:1]};
            assign w_first    = {ain, {(FRAME_W-1){1'b0}}};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_done      = 1'b0;
        w_done_data = w_shift_in;
        w_done_perr = 1'b0;
        w_abort     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bit_en && sof) begin
                    w_shift_nxt = w_first;
                    w_count_nxt = CNT_W'(1);
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_en) begin
                    if (sof) begin
                        // Restart: this strobe's bit is data bit 0 of a new frame.
                        w_abort     = 1'b1;
                        w_shift_nxt = w_first;
                        w_count_nxt = CNT_W'(1);
                    end else begin
                        w_shift_nxt = w_shift_in;
                        if (r_count == LAST_CNT) begin
                            if (PAR_EN != 0) begin
                                w_count_nxt = r_count + 1'b1;
                                w_state_nxt = ST_PAR;
                            end else begin
                                w_done      = 1'b1;
                                w_count_nxt = '0;
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end
            end

            ST_PAR: begin
                if (bit_en) begin
                    if (sof) begin
                        w_abort     = 1'b1;
                        w_shift_nxt = w_first;
                        w_count_nxt = CNT_W'(1);
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_done      = 1'b1;
                        w_done_data = r_shift;
                        w_done_perr = (^r_shift) ^ ain ^ (PAR_ODD != 0);
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Output register. A completion loads when the register is empty or is
    // being consumed on this same edge; otherwise the new frame is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
            abort       <= 1'b0;
        end else begin
            abort <= w_abort;
            if (w_done) begin
                if (!frame_valid || frame_ready) begin
                    frame_data  <= w_done_data;
                    parity_err  <= w_done_perr;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
